regfile_dump: RTL and testbench



---
 rtl/regfile_dump.sv | 115 +++++++++++
 tb/tb_regfile_dump.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: walks registers FIRST_REG..LAST_REG through a debug read port and streams them out on valid/ready.
// Optional trailing XOR checksum beat is enabled by defining REGFILE_DUMP_CSUM_EN.
module regfile_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    output logic [4:0]  o_rf_raddr,
    input  logic [31:0] i_rf_rdata,
    output logic        o_dout_valid,
    input  logic        i_dout_ready,
    output logic [31:0] o_dout_data,
    output logic [4:0]  o_dout_idx,
    output logic        o_dout_last,
    output logic        o_busy,
    output logic        o_done
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [5:0] P_FIRST = 6'(FIRST_REG);
    localparam logic [5:0] P_LAST  = 6'(LAST_REG);
`ifdef REGFILE_DUMP_CSUM_EN
    localparam logic [5:0] P_END = P_LAST + 6'd1;
`else
    localparam logic [5:0] P_END = P_LAST;
`endif
    state_t      r_state, w_next;
    logic [5:0]  r_ptr;
    logic        r_valid, r_last, r_done;
    logic [31:0] r_data;
    logic [4:0]  r_idx;
    logic        w_ld, w_hs, w_cap, w_cap_last;
    logic [31:0] w_cap_data;
    logic [4:0]  w_cap_idx;

    assign w_hs  = r_valid && i_dout_ready;
    assign w_ld  = (!r_valid || i_dout_ready) && (r_ptr <= P_END);
    assign w_cap = !i_abort && ((r_state == IDLE) ? i_start : w_ld);

`ifdef REGFILE_DUMP_CSUM_EN
    logic [31:0] r_csum;
    logic        w_csum_beat;
    assign w_csum_beat = (r_ptr == P_END);
    // Fold every captured register into the checksum; a start reseeds it with the first value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_csum <= '0;
        else if (w_cap && !w_csum_beat)
            r_csum <= (r_state == IDLE) ? i_rf_rdata : (r_csum ^ i_rf_rdata);
    end
    assign w_cap_data = w_csum_beat ? r_csum : i_rf_rdata;
    assign w_cap_idx  = w_csum_beat ? 5'd0 : r_ptr[4:0];
    assign w_cap_last = w_csum_beat;
`else
    assign w_cap_data = i_rf_rdata;
    assign w_cap_idx  = r_ptr[4:0];
    assign w_cap_last = (r_ptr == P_LAST);
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state: abort wins, start leaves IDLE, handshake of the last beat ends the dump
    always_comb begin
        w_next = r_state;
        if (i_abort)
            w_next = IDLE;
        else if (r_state == IDLE && i_start)
            w_next = RUN;
        else if (r_state == RUN && w_hs && r_last)
            w_next = IDLE;
    end

    // Output beat register and read pointer; a valid beat holds until accepted or aborted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr   <= P_FIRST;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == RUN) && !i_abort && w_hs && r_last;
            if (w_next == IDLE) begin
                r_ptr   <= P_FIRST;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_cap) begin
                r_ptr   <= r_ptr + 6'd1;
                r_valid <= 1'b1;
                r_data  <= w_cap_data;
                r_idx   <= w_cap_idx;
                r_last  <= w_cap_last;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_rf_raddr   = r_ptr[4:0];
    assign o_dout_valid = r_valid;
    assign o_dout_data  = r_data;
    assign o_dout_idx   = r_idx;
    assign o_dout_last  = r_last;
    assign o_busy       = (r_state == RUN);
    assign o_done       = r_done;
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed tests of the register dump engine against a small register file model.
module tb_regfile_dump;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b0;
    logic [4:0]  raddr, idx;
    logic [31:0] rdata, data;
    logic        valid, last, busy, done;
    logic [31:0] rf [32];
    int          passed = 0, total = 0;
`ifdef REGFILE_DUMP_CSUM_EN
    localparam int EXP_BEATS = 33;
    localparam bit CSUM = 1'b1;
`else
    localparam int EXP_BEATS = 32;
    localparam bit CSUM = 1'b0;
`endif

    int          n_beats, last_hs_cyc, done_cyc, done_seen, unstable, busy_bad, timed_out;
    logic        done_busy;
    logic [4:0]  b_idx [64];
    logic [31:0] b_data [64];
    logic        b_last [64];
    logic        post_valid, post_busy, post_last, post_done;
    logic [31:0] post_data;
    logic [4:0]  post_idx, post_raddr;

    always #5 clk = ~clk;
    assign rdata = (raddr == 5'd0) ? 32'd0 : rf[raddr];

    regfile_dump dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .o_rf_raddr(raddr), .i_rf_rdata(rdata),
        .o_dout_valid(valid), .i_dout_ready(ready), .o_dout_data(data),
        .o_dout_idx(idx), .o_dout_last(last), .o_busy(busy), .o_done(done)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Drives one dump and records accepted beats; never compares anything itself
    task automatic collect(input int mode, input int restart_at, input int abort_idx, input int rst_idx, input int wr_cyc);
        logic sv = 1'b0, pl = 1'b0, r;
        logic [31:0] pd = '0;
        logic [4:0] pi = '0;
        n_beats = 0; last_hs_cyc = -1; done_cyc = -1; done_seen = 0;
        unstable = 0; busy_bad = 0; timed_out = 1; done_busy = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (done === 1'b1) begin
                done_seen++; done_cyc = cyc; done_busy = busy; timed_out = 0;
                break;
            end
            if (sv && (valid !== 1'b1 || data !== pd || idx !== pi || last !== pl)) unstable++;
            if (last_hs_cyc < 0 && busy !== 1'b1) busy_bad++;
            r = (mode == 0) || (cyc % 3 == 1);
            ready = r;
            start = (cyc == restart_at);
            if (cyc == wr_cyc) rf[5] = 32'hDEADBEEF;
            if (abort_idx >= 0 && valid === 1'b1 && int'(idx) == abort_idx) begin
                abort = 1'b1; ready = 1'b0;
                @(posedge clk); #1;
                abort = 1'b0;
                post_valid = valid; post_busy = busy;
                repeat (3) begin
                    if (done === 1'b1) done_seen++;
                    @(posedge clk); #1;
                end
                timed_out = 0;
                break;
            end
            if (rst_idx >= 0 && valid === 1'b1 && int'(idx) == rst_idx) begin
                #2 rst_n = 1'b0;
                #1;
                post_valid = valid; post_busy = busy; post_last = last; post_done = done;
                post_data = data; post_idx = idx; post_raddr = raddr;
                @(posedge clk); #1;
                rst_n = 1'b1;
                timed_out = 0;
                break;
            end
            if (valid === 1'b1 && r) begin
                if (n_beats < 64) begin
                    b_idx[n_beats] = idx; b_data[n_beats] = data; b_last[n_beats] = last;
                end
                n_beats++;
                if (last === 1'b1) last_hs_cyc = cyc;
            end
            sv = valid && !r; pd = data; pi = idx; pl = last;
            @(posedge clk); #1;
        end
        ready = 1'b0; start = 1'b0;
    endtask

    // Counts recorded beats that differ from the expected register sequence
    function automatic int seq_errors();
        int e = 0;
        logic [31:0] x = '0, v;
        for (int k = 0; k < n_beats && k < 64; k++) begin
            if (k < 32) begin
                v = (k == 0) ? 32'd0 : rf[k];
                x ^= v;
                if (b_idx[k] !== 5'(k) || b_data[k] !== v || b_last[k] !== ((k == 31) && !CSUM)) e++;
            end else if (b_idx[k] !== 5'd0 || b_data[k] !== x || b_last[k] !== 1'b1) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        #3;
        total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
        total++; if (data !== 32'd0) $display("FAIL reset_data: got %h want 0", data); else passed++;
        total++; if (idx !== 5'd0 || last !== 1'b0) $display("FAIL reset_idx_last: got %0d/%b want 0/0", idx, last); else passed++;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %b/%b want 0/0", busy, done); else passed++;
        total++; if (raddr !== 5'd0) $display("FAIL reset_raddr: got %0d want 0", raddr); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_dump();
        collect(0, -1, -1, -1, -1);
        total++; if (n_beats != EXP_BEATS) $display("FAIL full_beats: got %0d want %0d", n_beats, EXP_BEATS); else passed++;
        total++; if (seq_errors() != 0) $display("FAIL full_seq: got %0d bad beats want 0", seq_errors()); else passed++;
        total++; if (b_data[31] !== 32'h1F1F1F1F || b_idx[31] !== 5'd31) $display("FAIL full_beat31: got %h/%0d want 1f1f1f1f/31", b_data[31], b_idx[31]); else passed++;
        total++; if (b_data[0] !== 32'd0) $display("FAIL full_beat0: got %h want 0", b_data[0]); else passed++;
        total++; if (last_hs_cyc != EXP_BEATS) $display("FAIL full_last_cycle: got %0d want %0d", last_hs_cyc, EXP_BEATS); else passed++;
        total++; if (done_cyc != EXP_BEATS + 1) $display("FAIL full_done_cycle: got %0d want %0d", done_cyc, EXP_BEATS + 1); else passed++;
        total++; if (done_busy !== 1'b0 || busy_bad != 0) $display("FAIL full_busy: got done_busy=%b bad=%0d want 0/0", done_busy, busy_bad); else passed++;
    endtask

    task automatic test_stall();
        collect(1, -1, -1, -1, -1);
        total++; if (n_beats != EXP_BEATS) $display("FAIL stall_beats: got %0d want %0d", n_beats, EXP_BEATS); else passed++;
        total++; if (seq_errors() != 0) $display("FAIL stall_seq: got %0d bad beats want 0", seq_errors()); else passed++;
        total++; if (unstable != 0) $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable); else passed++;
        total++; if (done_seen != 1) $display("FAIL stall_done: got %0d want 1", done_seen); else passed++;
    endtask

    task automatic test_back_to_back();
        collect(0, 5, -1, -1, -1);
        total++; if (n_beats != EXP_BEATS) $display("FAIL restart_ignored_beats: got %0d want %0d", n_beats, EXP_BEATS); else passed++;
        total++; if (seq_errors() != 0) $display("FAIL restart_ignored_seq: got %0d bad want 0", seq_errors()); else passed++;
        collect(0, -1, -1, -1, -1);
        total++; if (n_beats != EXP_BEATS || done_seen != 1) $display("FAIL second_dump: got %0d beats done=%0d want %0d/1", n_beats, done_seen, EXP_BEATS); else passed++;
    endtask

    task automatic test_abort();
        collect(0, -1, 10, -1, -1);
        total++; if (n_beats != 10) $display("FAIL abort_beats: got %0d want 10", n_beats); else passed++;
        total++; if (post_valid !== 1'b0 || post_busy !== 1'b0) $display("FAIL abort_outputs: got valid=%b busy=%b want 0/0", post_valid, post_busy); else passed++;
        total++; if (done_seen != 0) $display("FAIL abort_no_done: got %0d want 0", done_seen); else passed++;
        collect(0, -1, -1, -1, -1);
        total++; if (b_idx[0] !== 5'd0 || n_beats != EXP_BEATS) $display("FAIL abort_restart: got idx0=%0d beats=%0d want 0/%0d", b_idx[0], n_beats, EXP_BEATS); else passed++;
    endtask

    task automatic test_coherency_reset();
        collect(0, -1, -1, -1, 2);
        total++; if (b_data[5] !== 32'hDEADBEEF) $display("FAIL write_visible: got %h want deadbeef", b_data[5]); else passed++;
        total++; if (seq_errors() != 0) $display("FAIL write_seq: got %0d bad want 0", seq_errors()); else passed++;
        collect(0, -1, -1, 20, -1);
        total++; if (post_valid !== 1'b0 || post_last !== 1'b0) $display("FAIL rst_valid_last: got %b/%b want 0/0", post_valid, post_last); else passed++;
        total++; if (post_data !== 32'd0 || post_idx !== 5'd0) $display("FAIL rst_data_idx: got %h/%0d want 0/0", post_data, post_idx); else passed++;
        total++; if (post_busy !== 1'b0 || post_done !== 1'b0 || post_raddr !== 5'd0) $display("FAIL rst_busy_done_raddr: got %b/%b/%0d want 0/0/0", post_busy, post_done, post_raddr); else passed++;
        collect(0, -1, -1, -1, -1);
        total++; if (n_beats != EXP_BEATS || seq_errors() != 0) $display("FAIL rst_new_dump: got %0d beats %0d bad want %0d/0", n_beats, seq_errors(), EXP_BEATS); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h01010101 * 32'(i);
        test_reset();
        test_full_dump();
        test_stall();
        test_back_to_back();
        test_abort();
        test_coherency_reset();
        if (timed_out != 0) begin
            total++;
            $display("FAIL final_timeout: got timed_out=%0d want 0", timed_out);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
